// File: rtl/chunked_addsub.sv
// chunked_addsub
//   Multi-cycle adder/subtractor. An N-bit operation is split into K = N/CHUNK
//   chunks that are added LSB-first, one chunk per clock, with the inter-chunk
//   carry held in a register. This keeps the carry chain CHUNK bits long.
//
//   Subtraction is done as a + ~b + ~c_in, so in sub mode c_out is the
//   inverted borrow. ovf is the signed-overflow flag: carry into the MSB
//   XOR carry out of the MSB.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  operand handshake; in_ready is high only in IDLE
//   a, b, sub, c_in     operands, mode (0 add / 1 sub), carry/borrow in
//   out_valid, out_ready result handshake; out_valid is high only in DONE
//   s, c_out, ovf       result, raw carry out of bit N-1, signed overflow
module chunked_addsub #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         c_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         ovf
);

  localparam int K  = N / CHUNK;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  // Operands latched on accept; b_q already holds ~b in sub mode.
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic             carry_q;
  logic [KW-1:0]    k_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             accept;
  logic             last_chunk;
  logic             msb_carry_in;

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign accept     = in_valid && in_ready;
  assign last_chunk = (k_q == K_LAST);

  assign a_chunk   = a_q[k_q*CHUNK +: CHUNK];
  assign b_chunk   = b_q[k_q*CHUNK +: CHUNK];
  assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

  // Sum bit = a ^ b ^ carry_in, so the carry into the top bit of the chunk
  // is recovered as a ^ b ^ sum. Only meaningful on the last chunk.
  assign msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      s       <= '0;
      c_out   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? ~c_in : c_in;
            k_q     <= '0;
          end
        end
        RUN: begin
          s[k_q*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry_q               <= chunk_sum[CHUNK];
          k_q                   <= k_q + 1'b1;
          if (last_chunk) begin
            c_out <= chunk_sum[CHUNK];
            ovf   <= msb_carry_in ^ chunk_sum[CHUNK];
          end
        end
        default: ;  // DONE: results held until the consumer takes them
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_addsub.sv
// tb_chunked_addsub
//   Directed vectors on a N=32/CHUNK=8 instance, hand-written backpressure
//   and mid-operation reset sequences, and random sweeps on CHUNK=32, 1, 4
//   instances compared against a full-width reference model.
module tb_chunked_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: returns {c_out, ovf, s} for a 32-bit operation.
  function automatic logic [33:0] ref_model(input logic [31:0] ra, input logic [31:0] rb,
                                            input logic rsub, input logic rcin);
    logic [31:0] be;
    logic        ci;
    logic [32:0] full;
    logic        c_msb;
    be    = rsub ? ~rb : rb;
    ci    = rsub ? ~rcin : rcin;
    full  = {1'b0, ra} + {1'b0, be} + {32'd0, ci};
    c_msb = ra[31] ^ be[31] ^ full[31];
    return {full[32], c_msb ^ full[32], full[31:0]};
  endfunction

  // ---------------- main instance: N=32, CHUNK=8 ----------------
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, s;
  logic        sub, c_in, c_out, ovf;

  chunked_addsub #(.N(32), .CHUNK(8)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .c_in     (c_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .c_out    (c_out),
    .ovf      (ovf)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] s;
    logic        c;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  // Drive operands at a falling edge, accept on the next rising edge, then
  // scramble the inputs so a design that samples late is caught.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic ts, input logic tc);
    @(negedge clk);
    check("in_ready before accept", {63'd0, in_ready}, 64'd1);
    a = ta; b = tb_v; sub = ts; c_in = tc; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; sub = ~ts; c_in = ~tc;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- sweep instances ----------------
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int CH = (g == 0) ? 32 : ((g == 1) ? 1 : 4);
    localparam int KK = 32 / CH;

    logic        rst_n_s, iv, ir, ov, orr, sb, ci, co, of;
    logic [31:0] aa, bb, ss;
    logic        done = 1'b0;

    chunked_addsub #(.N(32), .CHUNK(CH)) u_sweep (
      .clk      (clk),
      .rst_n    (rst_n_s),
      .in_valid (iv),
      .in_ready (ir),
      .a        (aa),
      .b        (bb),
      .sub      (sb),
      .c_in     (ci),
      .out_valid(ov),
      .out_ready(orr),
      .s        (ss),
      .c_out    (co),
      .ovf      (of)
    );

    initial begin
      logic [33:0] expv;
      int          lat;
      rst_n_s = 1'b0; iv = 1'b0; orr = 1'b0;
      aa = '0; bb = '0; sb = 1'b0; ci = 1'b0;
      repeat (2) @(negedge clk);
      rst_n_s = 1'b1;
      for (int n = 0; n < 300; n++) begin
        @(negedge clk);
        aa = $urandom; bb = $urandom; sb = 1'($urandom); ci = 1'($urandom);
        expv = ref_model(aa, bb, sb, ci);
        iv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
        aa = $urandom; bb = $urandom; sb = ~sb; ci = ~ci;
        lat = 0;
        while (!ov && lat < KK + 5) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
        end
        check($sformatf("sweep CHUNK=%0d latency", CH), 64'(lat), 64'(KK));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check($sformatf("sweep CHUNK=%0d result", CH), {29'd0, ov, co, of, ss}, {29'd0, 1'b1, expv});
        orr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        orr = 1'b0;
      end
      done = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int  lat;
    logic all_done;

    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{32'h0000FFFF, 32'h00000000, 1'b0, 1'b1, 32'h00010000, 1'b0, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000006, 1'b1, 1'b0};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; c_in = 1'b0;
    repeat (2) @(negedge clk);
    check("reset in_ready/out_valid", {62'd0, in_ready, out_valid}, 64'd2);
    check("reset s/c_out/ovf", {30'd0, c_out, ovf, s}, 64'd0);
    rst_n = 1'b1;

    // Directed vectors
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
      wait_done(lat);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd4);
      check($sformatf("vec%0d result", i), {30'd0, c_out, ovf, s},
            {30'd0, vecs[i].c, vecs[i].ovf, vecs[i].s});
      release_out();
      check($sformatf("vec%0d idle after release", i), {62'd0, in_ready, out_valid}, 64'd2);
    end

    // Backpressure: 0xDEADBEEF + 0x01010101 = 0xDFAEBFF0, no carry, no overflow
    start_op(32'hDEADBEEF, 32'h01010101, 1'b0, 1'b0);
    wait_done(lat);
    check("bp latency", 64'(lat), 64'd4);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = $urandom; b = $urandom;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp hold %0d", i), {28'd0, out_valid, in_ready, c_out, ovf, s},
            {28'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDFAEBFF0});
    end
    in_valid = 1'b0;
    release_out();
    check("bp in_ready after release", {62'd0, in_ready, out_valid}, 64'd2);

    // Reset in RUN at k=2 aborts the operation
    start_op(32'h11111111, 32'h22222222, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid-reset handshake", {62'd0, in_ready, out_valid}, 64'd2);
    check("mid-reset outputs", {30'd0, c_out, ovf, s}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    wait_done(lat);
    check("post-reset latency", 64'(lat), 64'd4);
    check("post-reset result", {30'd0, c_out, ovf, s}, {30'd0, 1'b0, 1'b0, 32'h23456789});
    release_out();

    // Wait for the sweep instances, bounded
    all_done = 1'b0;
    for (int i = 0; i < 60000 && !all_done; i++) begin
      @(posedge clk);
      all_done = g_sweep[0].done && g_sweep[1].done && g_sweep[2].done;
    end
    check("sweep completion", {63'd0, all_done}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
